// File: rtl/fetch_unit.sv
// Fetch unit: owns the fetch PC, captures 4-word icache bundles into a
// circular instruction queue and presents up to two instructions per cycle
// to decode. Redirects flush the queue and restart fetch at a new PC.
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'hBFC0_0000,
    parameter int unsigned QUEUE_DEPTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    output logic [31:0]     pc_o,
    input  logic [3:0][31:0] inst_i,
    input  logic            redirect_valid,
    input  logic [31:0]     redirect_pc,
    input  logic            dec_ready,
    output logic [1:0]      out_valid,
    output logic [31:0]     out_inst0,
    output logic [31:0]     out_inst1,
    output logic [31:0]     out_pc0,
    output logic [31:0]     out_pc1,
    output logic [31:0]     stall_cnt
);

    localparam int unsigned AW = $clog2(QUEUE_DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW-1:0] head_p1;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] free;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   stall_q, stall_d;
    logic          push;
    logic          blocked;
    logic [1:0]    pop_n;

    logic [31:0] pc_mem   [QUEUE_DEPTH];
    logic [31:0] inst_mem [QUEUE_DEPTH];

    // Redirect targets are word aligned; the low bits are dropped.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Push/stall decision and decode-facing outputs from start-of-cycle state.
    always_comb begin
        // Room is judged before this cycle's pops; pops never enable a push.
        free         = CW'(QUEUE_DEPTH) - count_q;
        push         = !redirect_valid && (free >= CW'(4));
        blocked      = !redirect_valid && (free < CW'(4));
        out_valid[0] = (count_q >= CW'(1)) && !redirect_valid;
        out_valid[1] = (count_q >= CW'(2)) && !redirect_valid;
        pop_n        = dec_ready ? ({1'b0, out_valid[0]} + {1'b0, out_valid[1]}) : 2'd0;
        head_p1      = head_q + AW'(1);
        out_inst0    = inst_mem[head_q];
        out_inst1    = inst_mem[head_p1];
        out_pc0      = pc_mem[head_q];
        out_pc1      = pc_mem[head_p1];
        pc_o         = pc_q;
        stall_cnt    = stall_q;
    end

    // Next-state for pointers, count, fetch PC and stall counter.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        pc_d    = pc_q;
        stall_d = stall_q;
        if (redirect_valid) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            pc_d    = {redirect_pc[31:2], 2'b00};
        end else begin
            head_d  = head_q + AW'(pop_n);
            count_d = count_q + (push ? CW'(4) : CW'(0)) - CW'(pop_n);
            if (push) begin
                tail_d = tail_q + AW'(4);
                pc_d   = pc_q + 32'd16;
            end
            if (blocked && (stall_q != 32'hFFFF_FFFF)) begin
                stall_d = stall_q + 32'd1;
            end
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            pc_q    <= RESET_PC;
            stall_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            pc_q    <= pc_d;
            stall_q <= stall_d;
        end
    end

    // Queue storage: a whole bundle is written at tail..tail+3, wrapping.
    always_ff @(posedge clk) begin
        if (push) begin
            for (int k = 0; k < 4; k++) begin
                pc_mem[tail_q + AW'(k)]   <= pc_q + 32'(4 * k);
                inst_mem[tail_q + AW'(k)] <= inst_i[k];
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an icache model returning word = address.
module tb_fetch_unit;

    logic             clk;
    logic             rst;
    logic [31:0]      pc_o;
    logic [3:0][31:0] inst_i;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic             dec_ready;
    logic [1:0]       out_valid;
    logic [31:0]      out_inst0;
    logic [31:0]      out_inst1;
    logic [31:0]      out_pc0;
    logic [31:0]      out_pc1;
    logic [31:0]      stall_cnt;

    int checks;
    int errors;

    fetch_unit #(
        .RESET_PC   (32'hBFC0_0000),
        .QUEUE_DEPTH(16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_o          (pc_o),
        .inst_i        (inst_i),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .dec_ready     (dec_ready),
        .out_valid     (out_valid),
        .out_inst0     (out_inst0),
        .out_inst1     (out_inst1),
        .out_pc0       (out_pc0),
        .out_pc1       (out_pc1),
        .stall_cnt     (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Icache model: each word equals its own address.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            inst_i[k] = pc_o + 32'(4 * k);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        dec_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        dec_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        #2;
        checks++;
        if (pc_o !== 32'hBFC0_0000) begin
            errors++;
            $display("FAIL reset_pc: got %h expected %h", pc_o, 32'hBFC0_0000);
        end
        checks++;
        if (out_valid !== 2'b00) begin
            errors++;
            $display("FAIL reset_valid: got %b expected 00", out_valid);
        end
        checks++;
        if (stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_stall: got %0d expected 0", stall_cnt);
        end
    endtask

    task automatic test_fill();
        do_reset();
        for (int e = 1; e <= 4; e++) begin
            step();
            checks++;
            if (pc_o !== 32'hBFC0_0000 + 32'(16 * e)) begin
                errors++;
                $display("FAIL fill_pc edge %0d: got %h expected %h", e, pc_o,
                         32'hBFC0_0000 + 32'(16 * e));
            end
        end
        checks++;
        if (out_valid !== 2'b11 || out_pc0 !== 32'hBFC0_0000 || out_pc1 !== 32'hBFC0_0004) begin
            errors++;
            $display("FAIL fill_head: got v=%b pc0=%h pc1=%h expected v=11 pc0=bfc00000 pc1=bfc00004",
                     out_valid, out_pc0, out_pc1);
        end
        for (int s = 1; s <= 3; s++) begin
            step();
            checks++;
            if (stall_cnt !== 32'(s) || pc_o !== 32'hBFC0_0040) begin
                errors++;
                $display("FAIL fill_stall %0d: got stall=%0d pc=%h expected stall=%0d pc=bfc00040",
                         s, stall_cnt, pc_o, s);
            end
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        exp_pc = 32'hBFC0_0000;
        do_reset();
        dec_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            #1;
            checks++;
            if (out_valid[1] && !out_valid[0]) begin
                errors++;
                $display("FAIL stream_valid_order cycle %0d: got %b expected slot1 only with slot0",
                         i, out_valid);
            end
            if (out_valid[0]) begin
                checks++;
                if (out_pc0 !== exp_pc || out_inst0 !== exp_pc) begin
                    errors++;
                    $display("FAIL stream_slot0 cycle %0d: got pc=%h inst=%h expected %h",
                             i, out_pc0, out_inst0, exp_pc);
                end
                exp_pc = exp_pc + 32'd4;
            end
            if (out_valid[1]) begin
                checks++;
                if (out_pc1 !== exp_pc || out_inst1 !== exp_pc) begin
                    errors++;
                    $display("FAIL stream_slot1 cycle %0d: got pc=%h inst=%h expected %h",
                             i, out_pc1, out_inst1, exp_pc);
                end
                exp_pc = exp_pc + 32'd4;
            end
            @(negedge clk);
        end
        // First cycle is empty, then two instructions every cycle.
        checks++;
        if (exp_pc !== 32'hBFC0_0318) begin
            errors++;
            $display("FAIL stream_throughput: got next pc %h expected bfc00318", exp_pc);
        end
        dec_ready = 1'b0;
    endtask

    task automatic test_redirect();
        do_reset();
        repeat (6) step();
        checks++;
        if (stall_cnt !== 32'd2) begin
            errors++;
            $display("FAIL redir_pre_stall: got %0d expected 2", stall_cnt);
        end
        // Queue is full and decode is ready; redirect must neither pop nor stall.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_1236;
        dec_ready      = 1'b1;
        #1;
        checks++;
        if (out_valid !== 2'b00) begin
            errors++;
            $display("FAIL redir_mask: got %b expected 00", out_valid);
        end
        step();
        redirect_valid = 1'b0;
        dec_ready      = 1'b0;
        #1;
        checks++;
        if (pc_o !== 32'h8000_1234 || out_valid !== 2'b00 || stall_cnt !== 32'd2) begin
            errors++;
            $display("FAIL redir_next: got pc=%h v=%b stall=%0d expected pc=80001234 v=00 stall=2",
                     pc_o, out_valid, stall_cnt);
        end
        step();
        checks++;
        if (out_valid !== 2'b11 || out_pc0 !== 32'h8000_1234 || out_pc1 !== 32'h8000_1238 ||
            out_inst1 !== 32'h8000_1238) begin
            errors++;
            $display("FAIL redir_first: got v=%b pc0=%h pc1=%h inst1=%h expected 11 80001234 80001238",
                     out_valid, out_pc0, out_pc1, out_inst1);
        end
        checks++;
        if (pc_o !== 32'h8000_1244 || stall_cnt !== 32'd2) begin
            errors++;
            $display("FAIL redir_pc_adv: got pc=%h stall=%0d expected 80001244 2", pc_o, stall_cnt);
        end
    endtask

    task automatic test_redirect_pop();
        // Two valid slots and dec_ready alongside a redirect.
        dec_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        #1;
        checks++;
        if (out_valid !== 2'b00) begin
            errors++;
            $display("FAIL rpop_mask: got %b expected 00", out_valid);
        end
        step();
        redirect_valid = 1'b0;
        dec_ready      = 1'b0;
        #1;
        checks++;
        if (pc_o !== 32'h0000_0100 || out_valid !== 2'b00 || stall_cnt !== 32'd2) begin
            errors++;
            $display("FAIL rpop_next: got pc=%h v=%b stall=%0d expected 00000100 00 2",
                     pc_o, out_valid, stall_cnt);
        end
        step();
        checks++;
        if (out_valid !== 2'b11 || out_pc0 !== 32'h0000_0100 || out_pc1 !== 32'h0000_0104) begin
            errors++;
            $display("FAIL rpop_head: got v=%b pc0=%h pc1=%h expected 11 00000100 00000104",
                     out_valid, out_pc0, out_pc1);
        end
        // Back-to-back redirects: the later target wins.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0500;
        step();
        redirect_pc = 32'h0000_0604;
        step();
        redirect_valid = 1'b0;
        #1;
        checks++;
        if (pc_o !== 32'h0000_0604 || out_valid !== 2'b00) begin
            errors++;
            $display("FAIL b2b_next: got pc=%h v=%b expected 00000604 00", pc_o, out_valid);
        end
        step();
        checks++;
        if (out_valid !== 2'b11 || out_pc0 !== 32'h0000_0604 || out_pc1 !== 32'h0000_0608) begin
            errors++;
            $display("FAIL b2b_head: got v=%b pc0=%h pc1=%h expected 11 00000604 00000608",
                     out_valid, out_pc0, out_pc1);
        end
    endtask

    task automatic test_blocked_pop();
        do_reset();
        repeat (5) step();   // full, stall 1
        dec_ready = 1'b1;
        step();              // pop 2 -> 14, blocked, stall 2
        dec_ready = 1'b1;
        // Start-of-cycle free is 2: push blocked even though pops make room.
        step();              // pop 2 -> 12, blocked, stall 3
        dec_ready = 1'b0;
        #1;
        checks++;
        if (stall_cnt !== 32'd3 || pc_o !== 32'hBFC0_0040) begin
            errors++;
            $display("FAIL blk_pop_cycle: got stall=%0d pc=%h expected 3 bfc00040", stall_cnt, pc_o);
        end
        checks++;
        if (out_pc0 !== 32'hBFC0_0010 || out_valid !== 2'b11) begin
            errors++;
            $display("FAIL blk_head: got pc0=%h v=%b expected bfc00010 11", out_pc0, out_valid);
        end
        step();              // free 4 -> push, count 16
        checks++;
        if (stall_cnt !== 32'd3 || pc_o !== 32'hBFC0_0050) begin
            errors++;
            $display("FAIL blk_push: got stall=%0d pc=%h expected 3 bfc00050", stall_cnt, pc_o);
        end
        step();              // full again
        checks++;
        if (stall_cnt !== 32'd4 || pc_o !== 32'hBFC0_0050) begin
            errors++;
            $display("FAIL blk_full: got stall=%0d pc=%h expected 4 bfc00050", stall_cnt, pc_o);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (6) step();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (pc_o !== 32'hBFC0_0000 || out_valid !== 2'b00 || stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: got pc=%h v=%b stall=%0d expected bfc00000 00 0",
                     pc_o, out_valid, stall_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_fill();
        test_stream();
        test_redirect();
        test_redirect_pop();
        test_blocked_pop();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Fetch-side initiator for the instruction cache port. It owns the architectural fetch PC, drives it to the icache, and captures the 4-word bundle the icache returns combinationally in the same cycle. The bundle is buffered in a circular instruction queue, and the unit presents up to 2 instructions per cycle to decode. It sits between branch resolution (redirect input) and decode.

Parameters:
RESET_PC, 32'hBFC0_0000, fetch PC loaded on reset.
QUEUE_DEPTH, 16, instruction queue entries; power of 2, minimum 8.

Ports:
clk  input  1  clock.
rst  input  1  asynchronous reset, active-high.
pc_o  output  32  fetch address to icache.
inst_i  input  4x32  icache bundle. inst_i[k] is the word at pc_o+4k; valid in the same cycle as pc_o.
redirect_valid  input  1  flush and refetch request.
redirect_pc  input  32  new fetch PC; bits[1:0] ignored (forced 0).
dec_ready  input  1  decode accepts every currently valid output slot.
out_valid  output  2  slot valid; out_valid[1] implies out_valid[0].
out_inst0, out_inst1  output  32 each  instruction at queue head / head+1.
out_pc0, out_pc1  output  32 each  PC of the corresponding slot.
stall_cnt  output  32  cycles in which a fetch was blocked by a full queue; saturating.

Behaviour:
- State: pc register; queue of {pc, inst} entries; head and tail pointers modulo QUEUE_DEPTH; count, width clog2(QUEUE_DEPTH)+1; stall_cnt.
- Reset (asynchronous, immediate on rst assertion, including mid-operation):
  - pc = RESET_PC, so pc_o = RESET_PC.
  - head = tail = count = 0, so out_valid = 0.
  - stall_cnt = 0.
- pc_o is the pc register directly, with no combinational path from inputs.
- Free space is computed from the start-of-cycle count: free = QUEUE_DEPTH - count. Pops in the same cycle do not create room.
- Push, when !redirect_valid and free >= 4:
  - At the clock edge, write entries tail..tail+3 = {pc+4k, inst_i[k]} for k = 0..3.
  - tail += 4 (wrapping); pc += 16 (32-bit wrap).
  - Pushed entries are visible on the outputs in the next cycle (1-cycle latency).
- Push blocked, when !redirect_valid and free < 4:
  - No write; pc holds.
  - stall_cnt += 1, saturating at 32'hFFFF_FFFF.
- Partial bundles are never pushed.
- Outputs (combinational from queue head):
  - out_valid[0] = (count >= 1) && !redirect_valid.
  - out_valid[1] = (count >= 2) && !redirect_valid.
  - Slot data (out_inst/out_pc) is don't-care when the slot is invalid.
- Pop: when dec_ready, head advances by popcount(out_valid) and count decreases by the same amount. A simultaneous push and pop updates count by +4 minus the number popped.
- Redirect (redirect_valid = 1) takes priority over push and pop:
  - At the edge: head = tail = count = 0; pc = {redirect_pc[31:2], 2'b00}.
  - No push; pops are suppressed because out_valid is masked.
  - stall_cnt is not incremented.
  - Next cycle: pc_o = new PC and out_valid = 0. Its bundle is pushed at that edge, so the first redirected instruction appears on out_pc0 two cycles after the redirect edge.
- Back-to-back redirects: the last one wins; every redirect cycle flushes.
- Unaligned redirect (word-aligned, not 16-byte aligned): the bundle starts at the redirect PC. No alignment to 16 bytes.
- Wrap-around: pointer arithmetic is modulo QUEUE_DEPTH. FIFO order is preserved across the boundary, and a bundle may straddle the wrap.
- Full: count == QUEUE_DEPTH is legal; no push is possible. Empty: count == 0 gives out_valid = 0.

Test Plan:
1. Release reset with dec_ready=0 and QUEUE_DEPTH=16 -> pc_o steps BFC00000, BFC00010, BFC00020, BFC00030 on edges 1-4, then holds at BFC00040. Count reaches 16 and stall_cnt increments 1, 2, 3, ... each subsequent cycle.
2. Icache model returns word = address, with dec_ready=1 held -> out_pc0/out_pc1 sequence BFC00000/BFC00004, BFC00008/BFC0000C, ...; out_inst equals out_pc; no gaps or duplicates over 100 cycles, including across pointer wrap.
3. Assert redirect_valid with redirect_pc=8000_1236 -> out_valid=0 in the redirect cycle. Next cycle pc_o=8000_1234 and out_valid=0. The following cycle out_pc0=8000_1234, out_pc1=8000_1238.
4. Redirect in the same cycle as dec_ready with 2 valid entries -> no pop, old entries never reappear, and stall_cnt is unchanged that cycle.
5. Hold count=13 (free 3) with dec_ready pulsed for one cycle -> the push is blocked in the pop cycle (stall_cnt +1). The next cycle free=5, so the push proceeds, and count goes 13 -> 11 -> 15.
6. Assert rst asynchronously mid-stream between edges -> pc_o=BFC00000, out_valid=0 and stall_cnt=0 immediately, before the next clk edge.
